// File: rtl/dram_rw_sched.sv
// Merges the DRAM read-address and write streams onto one command port.
// Reads are credit limited; writes are protected from read starvation.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   dramra_rdy/dramra_ack, i_dramra    read request handshake and address
//   dramw_rdy/dramw_ack                write request handshake
//   i_dramwa, i_dramwd, i_dramw_mask   write address, line data, word mask
//   cmd_rdy/cmd_ack                    command slot handshake
//   o_cmd_we/addr/wd/mask              command payload (wd/mask 0 on reads)
//   dramrd_rdy/dramrd_ack              snooped read-data handshake
//   o_ostd                             outstanding-read count
module dram_rw_sched #(
    parameter int GBW        = 32,
    parameter int DBW        = 16,
    parameter int CSIZE      = 32,
    parameter int MAX_OSTD   = 4,
    parameter int STARVE_LIM = 4,
    localparam int OW = $clog2(MAX_OSTD + 1),
    localparam int SW = $clog2(STARVE_LIM + 1),
    localparam int WDW = DBW * CSIZE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             dramra_rdy,
    output logic             dramra_ack,
    input  logic [GBW-1:0]   i_dramra,
    input  logic             dramw_rdy,
    output logic             dramw_ack,
    input  logic [GBW-1:0]   i_dramwa,
    input  logic [WDW-1:0]   i_dramwd,
    input  logic [CSIZE-1:0] i_dramw_mask,
    output logic             cmd_rdy,
    input  logic             cmd_ack,
    output logic             o_cmd_we,
    output logic [GBW-1:0]   o_cmd_addr,
    output logic [WDW-1:0]   o_cmd_wd,
    output logic [CSIZE-1:0] o_cmd_mask,
    input  logic             dramrd_rdy,
    input  logic             dramrd_ack,
    output logic [OW-1:0]    o_ostd
);

    logic             rdy_q, rdy_d;
    logic             we_q, we_d;
    logic [GBW-1:0]   addr_q, addr_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic [CSIZE-1:0] mask_q, mask_d;
    logic [OW-1:0]    ostd_q, ostd_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic          slot_free;
    logic          held_rd;
    logic [OW:0]   used;
    logic          credit_ok;
    logic          rd_ok;
    logic          starve_hit;
    logic          grant_w;
    logic          grant_r;
    logic          rd_issue;
    logic          rd_done;

    // A read parked in the slot already owns a credit.
    assign held_rd    = rdy_q && !we_q;
    assign used       = {1'b0, ostd_q} + {{OW{1'b0}}, held_rd};
    assign credit_ok  = used < (OW + 1)'(MAX_OSTD);
    assign rd_ok      = dramra_rdy && credit_ok;
    assign starve_hit = starve_q == SW'(STARVE_LIM);

    // Slot can reload in the same cycle its content is consumed.
    assign slot_free = !rdy_q || cmd_ack;
    assign grant_w   = !i_rst && slot_free && dramw_rdy
                     && (!rd_ok || starve_hit);
    assign grant_r   = !i_rst && slot_free && rd_ok && !grant_w;

    assign rd_issue = rdy_q && cmd_ack && !we_q;
    assign rd_done  = dramrd_rdy && dramrd_ack;

    assign dramra_ack = grant_r;
    assign dramw_ack  = grant_w;
    assign cmd_rdy    = rdy_q;
    assign o_cmd_we   = we_q;
    assign o_cmd_addr = addr_q;
    assign o_cmd_wd   = wd_q;
    assign o_cmd_mask = mask_q;
    assign o_ostd     = ostd_q;

    always_comb begin
        rdy_d  = rdy_q;
        we_d   = we_q;
        addr_d = addr_q;
        wd_d   = wd_q;
        mask_d = mask_q;
        if (grant_w) begin
            rdy_d  = 1'b1;
            we_d   = 1'b1;
            addr_d = i_dramwa;
            wd_d   = i_dramwd;
            mask_d = i_dramw_mask;
        end else if (grant_r) begin
            rdy_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = i_dramra;
            wd_d   = '0;
            mask_d = '0;
        end else if (cmd_ack) begin
            rdy_d  = 1'b0;
        end
    end

    always_comb begin
        ostd_d = ostd_q;
        if (rd_issue && !rd_done && ostd_q != OW'(MAX_OSTD)) begin
            ostd_d = ostd_q + OW'(1);
        end else if (rd_done && !rd_issue && ostd_q != '0) begin
            ostd_d = ostd_q - OW'(1);
        end
    end

    // Counts read wins over a waiting write; any idle write cycle clears it.
    always_comb begin
        starve_d = starve_q;
        if (!dramw_rdy || grant_w) begin
            starve_d = '0;
        end else if (grant_r && !starve_hit) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            mask_q   <= '0;
            ostd_q   <= '0;
            starve_q <= '0;
        end else begin
            rdy_q    <= rdy_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            mask_q   <= mask_d;
            ostd_q   <= ostd_d;
            starve_q <= starve_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(rd_done && !rd_issue && ostd_q == '0))
            else $error("dram_rw_sched: read data with none outstanding");
        end
    end
`endif

endmodule

// File: doc/dram_rw_sched.md
Name: dram_rw_sched

Overview:
- Merges the tile unit's DRAM read-address stream (output of the read arbiter) and its DRAM write stream onto one shared single-command DRAM port.
- Arbitrates reads against writes with bounded write starvation.
- Limits the number of outstanding reads using a credit counter that is returned by read-data handshakes.
- Holds the issued command in a one-entry output register.

Parameters:
- GBW, 32, global address width.
- DBW, 16, data word width.
- CSIZE, 32, words per DRAM line.
- MAX_OSTD, 4, maximum outstanding reads (at least 1).
- STARVE_LIM, 4, consecutive read grants allowed while a write is waiting (at least 1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- dramra_rdy  in  1  read request valid
- dramra_ack  out  1  read request accepted
- i_dramra  in  GBW  read address
- dramw_rdy  in  1  write request valid
- dramw_ack  out  1  write request accepted
- i_dramwa  in  GBW  write address
- i_dramwd  in  DBW x CSIZE  write data
- i_dramw_mask  in  CSIZE  write byte-word mask
- cmd_rdy  out  1  command valid
- cmd_ack  in  1  command consumed by DRAM
- o_cmd_we  out  1  1 = write, 0 = read
- o_cmd_addr  out  GBW  command address
- o_cmd_wd  out  DBW x CSIZE  write data (0 for reads)
- o_cmd_mask  out  CSIZE  write mask (0 for reads)
- dramrd_rdy  in  1  read data valid (snooped)
- dramrd_ack  in  1  read data accepted (snooped); a read completes when rdy && ack
- o_ostd  out  clog2(MAX_OSTD+1)  current outstanding-read count

Behaviour:
- Handshake convention:
  - A transfer occurs in the cycle where rdy && ack.
  - Ack is asserted only when rdy is high.
  - Requesters hold payload stable until acked.
  - cmd_ack is legal only while cmd_rdy = 1.
- Output slot:
  - A single register holds {we, addr, wd, mask}.
  - The slot is free when cmd_rdy = 0, or when cmd_ack = 1 in the current cycle (back-to-back issue).
  - On a grant the slot loads the winner and cmd_rdy = 1 on the next cycle (latency 1).
  - cmd_rdy falls after cmd_ack only if there is no new grant in that cycle.
- Read eligibility: rd_ok = dramra_rdy && credit available.
  - Credit available means (o_ostd + issued_unacked_read) < MAX_OSTD.
  - A read held in the slot counts against credits.
- Arbitration:
  - Evaluated only when the slot is free.
  - Only rd_ok: grant read, assert dramra_ack.
  - Only dramw_rdy: grant write, assert dramw_ack.
  - Both:
    - Grant write if starve_cnt == STARVE_LIM; otherwise grant read.
    - At most one ack per cycle.
- starve_cnt:
  - Increments on each read grant while dramw_rdy = 1, saturating at STARVE_LIM.
  - Clears on a write grant, or on any cycle where dramw_rdy = 0.
- o_ostd:
  - Increments when a read command handshakes (cmd_rdy && cmd_ack && !o_cmd_we).
  - Decrements on dramrd_rdy && dramrd_ack.
  - Both in the same cycle: unchanged.
  - Must never exceed MAX_OSTD or go below 0. A decrement at 0 is a protocol error; the counter saturates at 0 and a simulation assertion fires.
- Read payload: reads drive o_cmd_wd and o_cmd_mask to 0.
- Ordering: commands leave in grant order. No reordering of reads relative to writes; address hazards are the requester's concern.
- Reset (synchronous, i_rst = 1 at a clock edge):
  - Outputs: cmd_rdy = 0, o_cmd_we = 0, o_cmd_addr = 0, o_cmd_wd = 0, o_cmd_mask = 0, o_ostd = 0.
  - Internal: starve_cnt = 0.
  - dramra_ack and dramw_ack are 0 while i_rst = 1.
  - Reset mid-operation drops any held command and zeroes credits. The environment resets the DRAM model concurrently.
- dramra_ack and dramw_ack are combinational from current state and request inputs. They never depend combinationally on dramrd_*.

Test Plan:
- Reads only, cmd_ack tied 1, no read data returned: issue 0x100..0x103 back-to-back. Expect:
  - 4 read commands on consecutive cycles.
  - o_ostd = 4.
  - 5th request 0x104 not acked.
  - One dramrd handshake, then 0x104 issues 1 cycle later and o_ostd returns to 4.
- Simultaneous persistent read and write requests, STARVE_LIM = 4, credits unlimited by fast read return: expect the command sequence R,R,R,R,W,R,R,R,R,W.
- Write only, addr 0x2000, mask 0x0000FFFF, cmd_ack held 0 for 3 cycles: expect cmd_rdy held with stable payload, dramw_ack exactly once, and no second grant until cmd_ack.
- Read-command handshake and dramrd handshake in the same cycle with o_ostd = 2: expect o_ostd stays 2.
- Assert i_rst for 1 cycle while a write is held and o_ostd = 3: expect next cycle cmd_rdy = 0, o_ostd = 0, and the dropped write never appears.
- Back-to-back check: slot full and cmd_ack = 1 with a pending read: expect the new read granted that cycle and cmd_rdy continuously high.
